// File: rtl/block_memory_pkg.sv
// Shared cache/memory types.
// Owns the cache<->memory request/response structs, the geometry constants,
// the block_t payload type and the memory FSM state encoding.
// Optional build macro used by the block_memory top: BLOCK_MEMORY_STATS_EN.
package cache_structs_def;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int BLOCK_SIZE   = 4;
  // Byte offset inside one block (16 bytes with the defaults -> 4 bits).
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE * DATA_WIDTH / 8);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

  typedef struct packed {
    logic                  cs;
    logic                  rw;    // 1 = write
    logic [ADDR_WIDTH-1:0] addr;
    block_t                data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_busy = 2'd1,
    st_resp = 2'd2
  } mem_state_t;

endpackage

// File: rtl/block_memory_array.sv
// block_mem_array: single-port block store, synchronous write and registered
// read, written so that synthesis maps it onto block RAM.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to idx on the rising edge)
//   idx   - block index, shared by read and write
//   wdata - block to store
//   rdata - registered read of idx (read-first on a simultaneous write)
module block_mem_array
  import cache_structs_def::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  block_t           wdata,
  output block_t           rdata
);

  block_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/block_memory.sv
// block_memory: block-granular main-memory model behind the cache.
// One whole-block read or write is accepted at a time; after a programmable
// latency a single-cycle ack is returned, carrying read data for reads and
// zero data for writes.
// Handshake: a request is accepted on any rising edge where the FSM is idle
// and mem_req.cs is high; mem_req is ignored until the ack cycle has passed,
// so cs acts as valid and (state == st_idle) acts as ready.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   mem_req - request from the cache (cs, rw, addr, data)
//   mem_res - response to the cache (ack, data)
//   busy    - high while a transaction is outstanding
//   rd_count, wr_count - saturating ack counters (only with BLOCK_MEMORY_STATS_EN)
module block_memory
  import cache_structs_def::*;
#(
  parameter int MEM_BLOCKS    = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  mem_req,
  output memory_response_t mem_res,
`ifdef BLOCK_MEMORY_STATS_EN
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count,
`endif
  output logic             busy
);

  localparam int              IDX_W   = $clog2(MEM_BLOCKS);
  localparam logic [7:0]      RD_INIT = 8'(READ_LATENCY - 1);
  localparam logic [7:0]      WR_INIT = 8'(WRITE_LATENCY - 1);

  mem_state_t       state, state_next;
  logic [7:0]       cnt, cnt_next;
  logic [IDX_W-1:0] idx_q, req_idx, arr_idx;
  logic             rw_q;
  logic             accept;
  logic             we;
  block_t           rdata;
  block_t           data_q, data_next;

  // Offset bits and anything above the index are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_req.addr;

  assign req_idx = mem_req.addr[OFFSET_WIDTH +: IDX_W];
  // While idle the array looks at the live request so a write commits on the
  // acceptance edge; afterwards it stays on the latched index, which keeps
  // the registered read output valid by the time the counter expires.
  assign arr_idx = (state == st_idle) ? req_idx : idx_q;
  // Reset wins over a simultaneous request.
  assign we      = accept & mem_req.rw & ~rst;

  block_mem_array #(
    .DEPTH (MEM_BLOCKS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (arr_idx),
    .wdata (mem_req.data),
    .rdata (rdata)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    data_next  = data_q;
    accept     = 1'b0;
    case (state)
      st_idle: begin
        if (mem_req.cs) begin
          accept     = 1'b1;
          cnt_next   = mem_req.rw ? WR_INIT : RD_INIT;
          state_next = st_busy;
        end
      end
      st_busy: begin
        if (cnt == 8'd0) begin
          data_next  = rw_q ? '0 : rdata;
          state_next = st_resp;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      st_resp: begin
        data_next  = '0;
        state_next = st_idle;
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= st_idle;
      cnt    <= 8'd0;
      data_q <= '0;
      idx_q  <= '0;
      rw_q   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      data_q <= data_next;
      if (accept) begin
        idx_q <= req_idx;
        rw_q  <= mem_req.rw;
      end
    end
  end

  assign mem_res.ack  = (state == st_resp);
  assign mem_res.data = data_q;
  assign busy         = (state != st_idle);

`ifdef BLOCK_MEMORY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (state == st_resp) begin
      if (rw_q) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_memory.sv
// Bench for block_memory with a 16-block store so address wrap is reachable.
// A simple array model indexed by (addr / block_bytes) mod 16 predicts every
// read, and an expected-data queue is matched against each ack.
module tb_block_memory;
  import cache_structs_def::*;

  localparam int MB     = 16;
  localparam int RL     = 4;
  localparam int WL     = 4;
  localparam int BBYTES = BLOCK_SIZE * DATA_WIDTH / 8;
  localparam int BW     = $bits(block_t);

  logic             clk = 1'b0;
  logic             rst;
  memory_request_t  mem_req;
  memory_response_t mem_res;
  logic             busy;
`ifdef BLOCK_MEMORY_STATS_EN
  logic [31:0]      rd_count;
  logic [31:0]      wr_count;
`endif

  int               checks   = 0;
  int               failures = 0;
  block_t           model [MB];
  int               n_rd = 0;
  int               n_wr = 0;
  logic [BW-1:0]    exp_q [$];

  block_memory #(
    .MEM_BLOCKS    (MB),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_res  (mem_res),
`ifdef BLOCK_MEMORY_STATS_EN
    .rd_count (rd_count),
    .wr_count (wr_count),
`endif
    .busy     (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int blk(input logic [31:0] a);
    return int'((a / BBYTES) % MB);
  endfunction

  function automatic block_t rand_block();
    block_t b;
    for (int i = 0; i < BLOCK_SIZE; i++) b[i] = $urandom;
    return b;
  endfunction

  // ---------------- driver ----------------
  // Entered at posedge+1 with the DUT idle. Drives one request, checks it is
  // accepted on the next edge, waits (bounded) for the ack, checks latency,
  // data, and that ack lasts one cycle. With hold=1 cs stays high through the
  // busy phase and the address/rw are changed two cycles after acceptance.
  task automatic do_txn(input logic rw, input logic [31:0] addr, input block_t data, input bit hold);
    int     n;
    block_t exp;
    mem_req.cs   = 1'b1;
    mem_req.rw   = rw;
    mem_req.addr = addr;
    mem_req.data = data;
    if (rw) begin
      exp = '0;
      model[blk(addr)] = data;
      n_wr++;
    end else begin
      exp = model[blk(addr)];
      n_rd++;
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (!hold) begin
      mem_req.cs   = 1'b0;
      mem_req.addr = $urandom;
      mem_req.data = rand_block();
    end
    check("accept_busy", busy, 1);
    n = 0;
    while (mem_res.ack !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (hold && n == 2) begin
        mem_req.addr = 32'h80;
        mem_req.rw   = ~rw;
        mem_req.data = rand_block();
      end
    end
    mem_req.cs = 1'b0;
    check("ack_latency", n, rw ? WL : RL);
    check("ack_busy", busy, 1);
    check("ack_data", mem_res.data, exp_q.pop_front());
    @(posedge clk); #1;
    check("ack_width", mem_res.ack, 0);
    check("idle_busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    block_t d;
    bit     seen;
    rst     = 1'b1;
    mem_req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ack", mem_res.ack, 0);
    check("rst_data", mem_res.data, 0);
    check("rst_busy", busy, 0);
`ifdef BLOCK_MEMORY_STATS_EN
    check("rst_rd_count", rd_count, 0);
    check("rst_wr_count", wr_count, 0);
`endif

    // Fill every block so later reads are fully predicted.
    for (int i = 0; i < MB; i++)
      do_txn(1'b1, i * BBYTES + $urandom_range(0, BBYTES - 1), rand_block(), 1'b0);

    // Write then read back at 0x40; the read follows the ack with no gap.
    for (int i = 0; i < BLOCK_SIZE; i++) d[i] = DATA_WIDTH'(i + 1);
    do_txn(1'b1, 32'h40, d, 1'b0);
    do_txn(1'b0, 32'h40, '0, 1'b0);
    // Offset bits ignored.
    do_txn(1'b0, 32'h44, '0, 1'b0);
    // Wrap-around: 0x40 + 16 blocks aliases to block 4.
    do_txn(1'b1, 32'h40 + MB * BBYTES, rand_block(), 1'b0);
    do_txn(1'b0, 32'h40, '0, 1'b0);
    // Request changed while busy: must still return block 0x40.
    do_txn(1'b1, 32'h80, rand_block(), 1'b0);
    do_txn(1'b0, 32'h40, '0, 1'b1);
    do_txn(1'b1, 32'h40, rand_block(), 1'b1);
    do_txn(1'b0, 32'h40, '0, 1'b0);

    // Reset two cycles into a read: no ack, busy drops, counters clear.
    mem_req.cs   = 1'b1;
    mem_req.rw   = 1'b0;
    mem_req.addr = 32'h40;
    @(posedge clk); #1;
    mem_req.cs = 1'b0;
    check("rst_txn_busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", mem_res.ack, 0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_res.ack === 1'b1) seen = 1'b1;
    end
    check("no_ack_after_rst", seen, 0);
`ifdef BLOCK_MEMORY_STATS_EN
    check("mid_rst_rd_count", rd_count, 0);
    check("mid_rst_wr_count", wr_count, 0);
`endif
    n_rd = 0;
    n_wr = 0;
    // A write committed before the reset is still readable.
    do_txn(1'b0, 32'h40, '0, 1'b0);

    // Randomized mix against the model.
    for (int i = 0; i < 40; i++)
      do_txn(1'($urandom_range(0, 1)), $urandom, rand_block(), 1'($urandom_range(0, 1)));

`ifdef BLOCK_MEMORY_STATS_EN
    check("final_rd_count", rd_count, n_rd);
    check("final_wr_count", wr_count, n_wr);
`endif
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
